// File: rtl/clock_divider_bank.sv
// Bank of run-time programmable 50%-duty integer clock dividers.
// Divisor changes land only on period boundaries; odd divisors use a negedge flop.
module clock_divider_bank #(
  parameter int NUM_CH      = 4,
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 5,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_in,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] enable,
  input  logic              div_wr,
  input  logic [CH_W-1:0]   div_ch,
  input  logic [DIV_W-1:0]  div_val,
  output logic              div_ack,
  output logic              div_err,
  input  logic              sync_restart,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  typedef logic [DIV_W-1:0] div_t;

  localparam div_t DEF = div_t'(DEFAULT_DIV);
  localparam div_t ONE = div_t'(1);

  div_t d_act_q  [NUM_CH];
  div_t d_act_d  [NUM_CH];
  div_t d_pend_q [NUM_CH];
  div_t d_pend_d [NUM_CH];
  div_t cnt_q    [NUM_CH];
  div_t cnt_d    [NUM_CH];
  div_t nd       [NUM_CH];

  logic [NUM_CH-1:0] pend_q, pend_d;
  logic [NUM_CH-1:0] p_q, p_d;
  logic [NUM_CH-1:0] n_q;
  logic [NUM_CH-1:0] odd_q, odd_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] last, wrap, idle_app;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              wr_ok;

  always_comb begin
    wr_ok = div_wr && (div_val > ONE)
            && (int'(div_ch) < NUM_CH);
    ack_d = wr_ok;
    err_d = div_wr && !wr_ok;
    for (int i = 0; i < NUM_CH; i++) begin
      d_act_d[i]  = d_act_q[i];
      d_pend_d[i] = d_pend_q[i];
      cnt_d[i]    = cnt_q[i];
      pend_d[i]   = pend_q[i];
      p_d[i]      = p_q[i];
      odd_d[i]    = odd_q[i];
      tick_d[i]   = 1'b0;
      nd[i]       = pend_q[i] ? d_pend_q[i]
                              : d_act_q[i];
      last[i]     = cnt_q[i] == (d_act_q[i] - ONE);
      wrap[i]     = enable[i]
                    && (last[i] || sync_restart);
      idle_app[i] = !enable[i] && last[i]
                    && pend_q[i];
      if (wrap[i]) begin
        d_act_d[i] = nd[i];
        pend_d[i]  = 1'b0;
        cnt_d[i]   = '0;
        p_d[i]     = 1'b1;
        odd_d[i]   = nd[i][0];
        tick_d[i]  = 1'b1;
      end else if (idle_app[i]) begin
        // Idle channels park at D-1 so the next enable wraps at once.
        d_act_d[i] = nd[i];
        pend_d[i]  = 1'b0;
        cnt_d[i]   = nd[i] - ONE;
      end else if (!last[i]) begin
        cnt_d[i] = cnt_q[i] + ONE;
        if (cnt_d[i] == (d_act_q[i] >> 1))
          p_d[i] = 1'b0;
      end
      if (wr_ok && (int'(div_ch) == i)) begin
        d_pend_d[i] = div_val;
        pend_d[i]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        d_act_q[i]  <= DEF;
        d_pend_q[i] <= DEF;
        cnt_q[i]    <= DEF - ONE;
      end
      pend_q <= '0;
      p_q    <= '0;
      odd_q  <= '0;
      tick_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        d_act_q[i]  <= d_act_d[i];
        d_pend_q[i] <= d_pend_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      pend_q <= pend_d;
      p_q    <= p_d;
      odd_q  <= odd_d;
      tick_q <= tick_d;
      ack_q  <= ack_d;
      err_q  <= err_d;
    end
  end

  // Half-cycle extension of the high phase for odd divisors.
  always_ff @(negedge clk_in or negedge reset_n) begin
    if (!reset_n) n_q <= '0;
    else          n_q <= p_q;
  end

  assign clk_out = p_q | (n_q & odd_q);
  assign tick    = tick_q;
  assign pending = pend_q;
  assign div_ack = ack_q;
  assign div_err = err_q;

endmodule

// File: tb/tb_clock_divider_bank.sv
// Bench for clock_divider_bank: period-level model checked every half cycle,
// plus directed literal checks on acks, errors, restarts and reset.
module tb_clock_divider_bank;

  localparam int NCH = 3;
  localparam int DW  = 8;

  logic           clk_in = 1'b0;
  logic           reset_n;
  logic [NCH-1:0] enable;
  logic           div_wr;
  logic [1:0]     div_ch;
  logic [DW-1:0]  div_val;
  logic           div_ack, div_err;
  logic           sync_restart;
  logic [NCH-1:0] pending, clk_out, tick;

  clock_divider_bank #(
    .NUM_CH(NCH), .DIV_W(DW), .DEFAULT_DIV(5)
  ) dut (
    .clk_in(clk_in), .reset_n(reset_n),
    .enable(enable), .div_wr(div_wr),
    .div_ch(div_ch), .div_val(div_val),
    .div_ack(div_ack), .div_err(div_err),
    .sync_restart(sync_restart),
    .pending(pending), .clk_out(clk_out),
    .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t",
                  nm, act, exp, $time);
  endtask

  // Model: each channel is a sequence of periods, each with a start cycle.
  int m_d[NCH], m_dp[NCH], m_start[NCH];
  bit m_pend[NCH], m_act[NCH];
  int cyc = 0;
  bit e_ack, e_err;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_d[i] = 5; m_dp[i] = 5;
      m_pend[i] = 0; m_act[i] = 0;
    end
    e_ack = 0; e_err = 0;
  endfunction

  function automatic void model_step();
    cyc++;
    e_ack = 0; e_err = 0;
    for (int i = 0; i < NCH; i++) begin
      if (m_act[i] && (cyc - m_start[i] >= m_d[i]))
        m_act[i] = 0;
      if (enable[i] && (sync_restart || !m_act[i])) begin
        if (m_pend[i]) begin
          m_d[i] = m_dp[i]; m_pend[i] = 0;
        end
        m_start[i] = cyc; m_act[i] = 1;
      end else if (!enable[i] && !m_act[i]
                   && m_pend[i]) begin
        m_d[i] = m_dp[i]; m_pend[i] = 0;
      end
    end
    if (div_wr) begin
      if (int'(div_val) >= 2 && int'(div_ch) < NCH) begin
        m_dp[int'(div_ch)] = int'(div_val);
        m_pend[int'(div_ch)] = 1;
        e_ack = 1;
      end else e_err = 1;
    end
  endfunction

  function automatic int exp_hi(int i, bit second);
    int k;
    if (!m_act[i]) return 0;
    k = cyc - m_start[i];
    if (!second) return int'(k < (m_d[i] + 1) / 2);
    return int'(k < m_d[i] / 2);
  endfunction

  function automatic int exp_tick(int i);
    return int'(m_act[i] && (cyc == m_start[i]));
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk_in);
      if (!reset_n) model_reset();
      else model_step();
      #1;
      for (int i = 0; i < NCH; i++) begin
        chk($sformatf("clk_hi%0d", i),
            int'(clk_out[i]), exp_hi(i, 0));
        chk($sformatf("tick%0d", i),
            int'(tick[i]), exp_tick(i));
        chk($sformatf("pend%0d", i),
            int'(pending[i]), int'(m_pend[i]));
      end
      chk("ack", int'(div_ack), int'(e_ack));
      chk("err", int'(div_err), int'(e_err));
      @(negedge clk_in);
      #1;
      if (!reset_n) model_reset();
      for (int i = 0; i < NCH; i++)
        chk($sformatf("clk_lo%0d", i),
            int'(clk_out[i]), exp_hi(i, 1));
    end
  end

  task automatic wait_tick(input int ch);
    bit got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(posedge clk_in); #2;
      got = tick[ch];
    end
    chk("tick_wait", int'(got), 1);
  endtask

  task automatic wr(input int ch, input int v);
    div_wr = 1'b1;
    div_ch = 2'(ch);
    div_val = DW'(v);
  endtask

  int tcnt[NCH];

  initial begin
    reset_n = 0; enable = '0; div_wr = 0;
    div_ch = '0; div_val = '0; sync_restart = 0;
    repeat (2) @(negedge clk_in);
    chk("rst_clk", int'(clk_out), 0);
    chk("rst_pend", int'(pending), 0);
    chk("rst_tick", int'(tick), 0);
    reset_n = 1; enable = '1;
    @(posedge clk_in); #2;
    chk("first_rise", int'(clk_out), 7);
    chk("first_tick", int'(tick), 7);
    repeat (11) @(negedge clk_in);

    wr(1, 4);
    @(posedge clk_in); #2;
    chk("ack_ch1", int'(div_ack), 1);
    chk("pend_ch1", int'(pending), 3'b010);
    @(negedge clk_in);
    wr(2, 7);
    @(posedge clk_in); #2;
    chk("ack_ch2", int'(div_ack), 1);
    chk("pend_ch2", int'(pending), 3'b110);
    @(negedge clk_in);
    div_wr = 0;
    repeat (20) @(negedge clk_in);
    chk("pend_clear", int'(pending), 0);

    wr(0, 1);
    @(posedge clk_in); #2;
    chk("err_v1", int'(div_err), 1);
    chk("noack_v1", int'(div_ack), 0);
    @(negedge clk_in);
    wr(0, 0);
    @(posedge clk_in); #2;
    chk("err_v0", int'(div_err), 1);
    @(negedge clk_in);
    wr(3, 6);
    @(posedge clk_in); #2;
    chk("err_ch", int'(div_err), 1);
    chk("err_nopend", int'(pending), 0);
    @(negedge clk_in);
    div_wr = 0;
    repeat (3) @(negedge clk_in);

    wait_tick(0);
    @(negedge clk_in);
    @(negedge clk_in);
    enable[0] = 1'b0;
    wr(0, 3);
    @(negedge clk_in);
    div_wr = 0;
    repeat (8) @(negedge clk_in);
    chk("dis_low", int'(clk_out[0]), 0);
    chk("dis_applied", int'(pending[0]), 0);
    enable[0] = 1'b1;
    @(posedge clk_in); #2;
    chk("reen_rise", int'(clk_out[0]), 1);
    chk("reen_tick", int'(tick[0]), 1);
    @(negedge clk_in);
    wr(2, 6);
    @(negedge clk_in);
    div_wr = 0;
    repeat (5) @(negedge clk_in);

    sync_restart = 1;
    for (int i = 0; i < NCH; i++) tcnt[i] = 0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_in); #2;
      for (int c = 0; c < NCH; c++)
        tcnt[c] += int'(tick[c]);
      if (i == 0) begin
        chk("sync_rise", int'(clk_out), 7);
        chk("sync_tick", int'(tick), 7);
        @(negedge clk_in);
        sync_restart = 0;
      end
      if (i == 12) chk("align12", int'(tick), 7);
    end
    chk("ticks_d3", tcnt[0], 8);
    chk("ticks_d4", tcnt[1], 6);
    chk("ticks_d6", tcnt[2], 4);

    @(negedge clk_in);
    sync_restart = 1;
    wr(1, 5);
    @(posedge clk_in); #2;
    chk("sw_rise", int'(clk_out), 7);
    chk("sw_ack", int'(div_ack), 1);
    chk("sw_pend", int'(pending), 3'b010);
    @(negedge clk_in);
    sync_restart = 0; div_wr = 0;
    repeat (10) @(negedge clk_in);

    wait_tick(1);
    #1;
    reset_n = 0;
    #1;
    chk("async_rst", int'(clk_out), 0);
    @(negedge clk_in);
    @(negedge clk_in);
    reset_n = 1;
    chk("rst2_pend", int'(pending), 0);
    @(posedge clk_in); #2;
    chk("rst2_rise", int'(clk_out), 7);
    chk("rst2_tick", int'(tick), 7);
    repeat (12) @(negedge clk_in);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
